// File: rtl/conv_mem_scheduler_if.sv
// Purpose : command/pixel inputs and line-memory/convolver control outputs of
//           conv_mem_scheduler, bundled as one interface.
// Modports: master - command source (GPIO decoder / testbench), drives i_*.
//           slave  - the scheduler, drives o_*.
// Signals : i_img_len/i_len_valid   row-length command
//           i_load_pixel/i_load_valid pixel stream
//           i_sop                    start-of-processing pulse
//           o_we/o_wr_addr/o_wr_data line-memory write port
//           o_rd_en/o_rd_addr        shared read port of MEM0..MEM2
//           o_mem_sel                index of the oldest row
//           o_conv_valid             convolver input valid
//           o_load_full/o_busy/o_done/o_err status
interface conv_mem_scheduler_if #(
  parameter int unsigned BIT_LEN    = 8,
  parameter int unsigned NB_ADDRESS = 10,
  parameter int unsigned NB_IMAGE   = 10
);
  logic [NB_IMAGE-1:0]   i_img_len;
  logic                  i_len_valid;
  logic [BIT_LEN-1:0]    i_load_pixel;
  logic                  i_load_valid;
  logic                  i_sop;
  logic [2:0]            o_we;
  logic [NB_ADDRESS-1:0] o_wr_addr;
  logic [BIT_LEN-1:0]    o_wr_data;
  logic                  o_rd_en;
  logic [NB_ADDRESS-1:0] o_rd_addr;
  logic [1:0]            o_mem_sel;
  logic                  o_conv_valid;
  logic                  o_load_full;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;

  modport master (
    output i_img_len, i_len_valid, i_load_pixel, i_load_valid, i_sop,
    input  o_we, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr, o_mem_sel,
           o_conv_valid, o_load_full, o_busy, o_done, o_err
  );

  modport slave (
    input  i_img_len, i_len_valid, i_load_pixel, i_load_valid, i_sop,
    output o_we, o_wr_addr, o_wr_data, o_rd_en, o_rd_addr, o_mem_sel,
           o_conv_valid, o_load_full, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_mem_scheduler.sv
// Purpose : sequences the three image line memories feeding the 2D convolver.
//           Pixels are written into MEM0..MEM2 as a round-robin ring of rows;
//           on SOP the shared read address sweeps 0..len-1, the convolver valid
//           follows the read enable by RAM_LATENCY cycles, and the ring keeps
//           the oldest row as the next write target.
// Ports   : CLK100MHZ - clock
//           i_rst     - asynchronous active-high reset
//           io_bus    - conv_mem_scheduler_if.slave (commands in, memory and
//                       convolver control out); all outputs are registered.
module conv_mem_scheduler #(
  parameter int unsigned BIT_LEN     = 8,
  parameter int unsigned NB_ADDRESS  = 10,
  parameter int unsigned NB_IMAGE    = 10,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                CLK100MHZ,
  input  logic                i_rst,
  conv_mem_scheduler_if.slave io_bus
);

  // Common width wide enough for lengths up to 2^NB_ADDRESS
  localparam int unsigned   CW      = ((NB_ADDRESS > NB_IMAGE) ? NB_ADDRESS : NB_IMAGE) + 1;
  localparam int unsigned   DW      = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(1) << NB_ADDRESS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             r_state,     w_nxt_state;
  logic [NB_IMAGE-1:0]    r_len,       w_nxt_len;
  logic [1:0]             r_wp,        w_nxt_wp;
  logic [NB_ADDRESS-1:0]  r_wcnt,      w_nxt_wcnt;
  logic [1:0]             r_rows,      w_nxt_rows;
  logic [NB_ADDRESS-1:0]  r_rcnt,      w_nxt_rcnt;
  logic [DW-1:0]          r_dcnt,      w_nxt_dcnt;
  logic [2:0]             r_we,        w_nxt_we;
  logic [NB_ADDRESS-1:0]  r_wr_addr,   w_nxt_wr_addr;
  logic [BIT_LEN-1:0]     r_wr_data,   w_nxt_wr_data;
  logic                   r_rd_en,     w_nxt_rd_en;
  logic [NB_ADDRESS-1:0]  r_rd_addr,   w_nxt_rd_addr;
  logic [1:0]             r_mem_sel,   w_nxt_mem_sel;
  logic                   r_load_full, w_nxt_load_full;
  logic                   r_busy,      w_nxt_busy;
  logic                   r_done,      w_nxt_done;
  logic                   r_err,       w_nxt_err;
  logic [RAM_LATENCY-1:0] r_vpipe;

  logic w_row_last, w_rd_last, w_len_in_range;
  logic w_sop_ok, w_load_ok, w_len_ok, w_multi;

  // Command legality and end-of-row / end-of-sweep detection
  assign w_row_last     = (CW'(r_wcnt) == (CW'(r_len) - CW'(1)));
  assign w_rd_last      = (CW'(r_rcnt) == (CW'(r_len) - CW'(1)));
  assign w_len_in_range = (CW'(io_bus.i_img_len) != '0) && (CW'(io_bus.i_img_len) <= MAX_LEN);
  assign w_sop_ok       = (r_state == S_IDLE) && (r_rows == 2'd3);
  assign w_load_ok      = ((r_state == S_IDLE) || (r_state == S_LOAD)) &&
                          (r_len != '0) && (r_rows != 2'd3);
  assign w_len_ok       = (r_state == S_IDLE) && (r_rows == 2'd0) && w_len_in_range;
  assign w_multi        = (io_bus.i_sop & io_bus.i_load_valid) |
                          (io_bus.i_sop & io_bus.i_len_valid) |
                          (io_bus.i_load_valid & io_bus.i_len_valid);

  // Next-state and registered-output logic
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_len     = r_len;
    w_nxt_wp      = r_wp;
    w_nxt_wcnt    = r_wcnt;
    w_nxt_rows    = r_rows;
    w_nxt_rcnt    = r_rcnt;
    w_nxt_dcnt    = r_dcnt;
    w_nxt_we      = 3'b000;
    w_nxt_wr_addr = r_wr_addr;
    w_nxt_wr_data = r_wr_data;
    w_nxt_rd_en   = 1'b0;
    w_nxt_rd_addr = r_rd_addr;
    w_nxt_done    = 1'b0;
    w_nxt_err     = 1'b0;

    // Sweep sequencing
    case (r_state)
      S_RUN: begin
        w_nxt_rd_en   = 1'b1;
        w_nxt_rd_addr = r_rcnt;
        w_nxt_rcnt    = r_rcnt + NB_ADDRESS'(1);
        if (w_rd_last) begin
          w_nxt_state = S_DRAIN;
          w_nxt_dcnt  = '0;
        end
      end
      S_DRAIN: begin
        w_nxt_dcnt = r_dcnt + DW'(1);
        if (r_dcnt == DW'(RAM_LATENCY - 1)) w_nxt_state = S_DONE;
      end
      S_DONE: begin
        // Oldest row becomes free; wp already points at it
        w_nxt_done  = 1'b1;
        w_nxt_rows  = 2'd2;
        w_nxt_state = S_IDLE;
      end
      default: ;
    endcase

    // Command arbitration: sop > load > len; only the winner may execute
    if (io_bus.i_sop) begin
      if (w_sop_ok) begin
        w_nxt_state = S_RUN;
        w_nxt_rcnt  = '0;
      end else begin
        w_nxt_err = 1'b1;
      end
    end else if (io_bus.i_load_valid) begin
      if (w_load_ok) begin
        w_nxt_we      = 3'b001 << r_wp;
        w_nxt_wr_addr = r_wcnt;
        w_nxt_wr_data = io_bus.i_load_pixel;
        if (w_row_last) begin
          w_nxt_wcnt  = '0;
          w_nxt_wp    = (r_wp == 2'd2) ? 2'd0 : (r_wp + 2'd1);
          w_nxt_rows  = r_rows + 2'd1;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_wcnt  = r_wcnt + NB_ADDRESS'(1);
          w_nxt_state = S_LOAD;
        end
      end else begin
        w_nxt_err = 1'b1;
      end
    end else if (io_bus.i_len_valid) begin
      if (w_len_ok) w_nxt_len = io_bus.i_img_len;
      else          w_nxt_err = 1'b1;
    end

    if (w_multi) w_nxt_err = 1'b1;
  end

  assign w_nxt_load_full = (w_nxt_rows == 2'd3);
  assign w_nxt_mem_sel   = w_nxt_load_full ? w_nxt_wp : r_mem_sel;
  assign w_nxt_busy      = (w_nxt_state == S_RUN) || (w_nxt_state == S_DRAIN) ||
                           (w_nxt_state == S_DONE);

  // State and output registers
  always_ff @(posedge CLK100MHZ or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_wp        <= '0;
      r_wcnt      <= '0;
      r_rows      <= '0;
      r_rcnt      <= '0;
      r_dcnt      <= '0;
      r_we        <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_mem_sel   <= '0;
      r_load_full <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_len       <= w_nxt_len;
      r_wp        <= w_nxt_wp;
      r_wcnt      <= w_nxt_wcnt;
      r_rows      <= w_nxt_rows;
      r_rcnt      <= w_nxt_rcnt;
      r_dcnt      <= w_nxt_dcnt;
      r_we        <= w_nxt_we;
      r_wr_addr   <= w_nxt_wr_addr;
      r_wr_data   <= w_nxt_wr_data;
      r_rd_en     <= w_nxt_rd_en;
      r_rd_addr   <= w_nxt_rd_addr;
      r_mem_sel   <= w_nxt_mem_sel;
      r_load_full <= w_nxt_load_full;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
      r_err       <= w_nxt_err;
    end
  end

  // Convolver valid tracks the read enable through the memory latency
  generate
    if (RAM_LATENCY > 1) begin : g_vpipe
      always_ff @(posedge CLK100MHZ or posedge i_rst) begin
        if (i_rst) r_vpipe <= '0;
        else       r_vpipe <= {r_vpipe[RAM_LATENCY-2:0], r_rd_en};
      end
    end else begin : g_vpipe1
      always_ff @(posedge CLK100MHZ or posedge i_rst) begin
        if (i_rst) r_vpipe <= '0;
        else       r_vpipe <= r_rd_en;
      end
    end
  endgenerate

  assign io_bus.o_we         = r_we;
  assign io_bus.o_wr_addr    = r_wr_addr;
  assign io_bus.o_wr_data    = r_wr_data;
  assign io_bus.o_rd_en      = r_rd_en;
  assign io_bus.o_rd_addr    = r_rd_addr;
  assign io_bus.o_mem_sel    = r_mem_sel;
  assign io_bus.o_conv_valid = r_vpipe[RAM_LATENCY-1];
  assign io_bus.o_load_full  = r_load_full;
  assign io_bus.o_busy       = r_busy;
  assign io_bus.o_done       = r_done;
  assign io_bus.o_err        = r_err;

endmodule
